syscall_ctrl: RTL and testbench

SYSCALL_CTRL -- requirements
Module: syscall_ctrl

---
 rtl/syscall_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_syscall_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/syscall_ctrl.sv
// Syscall controller: decodes CPU syscall requests and sequences the memory,
// trig table, video and print ports. Every output is driven from a register.
module syscall_ctrl #(
    parameter int STR_MAX = 256
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        sys_signal,
    input  logic [47:0] sysregs,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    output logic [9:0]  trig_addr,
    output logic        trig_re,
    input  logic [15:0] trig_rdata,
    output logic        load_signal,
    output logic [15:0] load_data,
    output logic        video_activate,
    output logic        video_clear,
    output logic        video_write,
    output logic [15:0] video_addr,
    output logic [15:0] video_data,
    output logic        print_valid,
    input  logic        print_ready,
    output logic [15:0] print_data,
    output logic        print_dec,
    output logic        halt,
    output logic        busy,
    output logic        overrun,
    output logic        bad_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_WRITE, S_READ, S_RDWAIT, S_VIDEO,
        S_PRINT, S_STRRD, S_STRWAIT, S_STROUT, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic        sys_prev_q;
    logic [15:0] code_q, code_d, arg_q, arg_d, data_q, data_d, idx_q, idx_d;
    logic        load_signal_q, load_signal_d;
    logic [15:0] load_data_q, load_data_d;
    logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d, mem_re_q, mem_re_d, trig_re_q, trig_re_d;
    logic [9:0]  trig_addr_q, trig_addr_d;
    logic        vid_act_q, vid_act_d, vid_clr_q, vid_clr_d, vid_wr_q, vid_wr_d;
    logic [15:0] vid_addr_q, vid_addr_d, vid_data_q, vid_data_d;
    logic        print_valid_q, print_valid_d, print_dec_q, print_dec_d;
    logic [15:0] print_data_q, print_data_d;
    logic        halt_q, halt_d, busy_q, busy_d, overrun_q, overrun_d;
    logic        bad_code_q, bad_code_d;
    logic        req_s, accept_s, trig_bad_s, last_s;

    assign req_s      = sys_signal & ~sys_prev_q;
    assign accept_s   = req_s && (state_q == S_IDLE);
    assign code_d     = accept_s ? sysregs[15:0]  : code_q;
    assign arg_d      = accept_s ? sysregs[31:16] : arg_q;
    assign data_d     = accept_s ? sysregs[47:32] : data_q;
    assign trig_bad_s = ((code_d == 16'd9) || (code_d == 16'd10)) && (arg_d >= 16'd360);
    assign last_s     = ({16'd0, idx_q} == 32'(STR_MAX - 1));

    // Next-state sequencing plus next values of every registered output
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        load_signal_d = load_signal_q;
        load_data_d   = load_data_q;
        print_data_d  = print_data_q;
        print_dec_d   = print_dec_q;
        halt_d        = halt_q;
        bad_code_d    = bad_code_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    load_signal_d = 1'b0;
                    case (code_d)
                        16'd0: begin
                            state_d = S_HALT;
                            halt_d  = 1'b1;
                        end
                        16'd1: state_d = S_WRITE;
                        16'd2: state_d = S_READ;
                        16'd3, 16'd4: begin
                            state_d      = S_PRINT;
                            print_data_d = arg_d;
                            print_dec_d  = (code_d == 16'd3);
                        end
                        16'd5: begin
                            state_d = S_STRRD;
                            idx_d   = 16'd0;
                        end
                        16'd6, 16'd7, 16'd8: state_d = S_VIDEO;
                        16'd9, 16'd10: begin
                            // Out-of-range angles still complete a read cycle, returning zero
                            state_d    = S_READ;
                            bad_code_d = bad_code_q | trig_bad_s;
                        end
                        default: bad_code_d = 1'b1;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE, S_VIDEO: state_d = S_IDLE;
            S_READ:           state_d = S_RDWAIT;
            S_RDWAIT: begin
                state_d       = S_IDLE;
                load_signal_d = 1'b1;
                if (code_q == 16'd2) begin
                    load_data_d = mem_rdata;
                end else if (trig_bad_s) begin
                    load_data_d = 16'd0;
                end else begin
                    load_data_d = trig_rdata & 16'h03FF;
                end
            end
            S_PRINT: state_d = print_ready ? S_IDLE : S_PRINT;
            S_STRRD: state_d = S_STRWAIT;
            S_STRWAIT: begin
                if (mem_rdata == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d      = S_STROUT;
                    print_data_d = mem_rdata;
                    print_dec_d  = 1'b0;
                end
            end
            S_STROUT: begin
                if (print_ready) begin
                    idx_d   = idx_q + 16'd1;
                    state_d = last_s ? S_IDLE : S_STRRD;
                end else begin
                    state_d = S_STROUT;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        overrun_d     = overrun_q | (req_s && (state_q != S_IDLE) && (state_q != S_HALT));
        mem_we_d      = (state_d == S_WRITE);
        mem_re_d      = ((state_d == S_READ) && (code_d == 16'd2)) || (state_d == S_STRRD);
        trig_re_d     = (state_d == S_READ) && (code_d != 16'd2) && !trig_bad_s;
        mem_addr_d    = (mem_we_d || mem_re_d) ? (arg_d + ((state_d == S_STRRD) ? idx_d : 16'd0))
                                               : mem_addr_q;
        mem_wdata_d   = mem_we_d ? data_d : mem_wdata_q;
        trig_addr_d   = trig_re_d ? {arg_d[8:0], (code_d == 16'd10)} : trig_addr_q;
        vid_act_d     = (state_d == S_VIDEO) && (code_d == 16'd6);
        vid_clr_d     = (state_d == S_VIDEO) && (code_d == 16'd7);
        vid_wr_d      = (state_d == S_VIDEO) && (code_d == 16'd8);
        vid_addr_d    = vid_wr_d ? arg_d  : vid_addr_q;
        vid_data_d    = vid_wr_d ? data_d : vid_data_q;
        print_valid_d = (state_d == S_PRINT) || (state_d == S_STROUT);
        busy_d        = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    // State and output registers, cleared asynchronously by clear_n
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q       <= S_IDLE;
            sys_prev_q    <= 1'b0;
            code_q        <= 16'd0;
            arg_q         <= 16'd0;
            data_q        <= 16'd0;
            idx_q         <= 16'd0;
            load_signal_q <= 1'b0;
            load_data_q   <= 16'd0;
            mem_addr_q    <= 16'd0;
            mem_wdata_q   <= 16'd0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            trig_re_q     <= 1'b0;
            trig_addr_q   <= 10'd0;
            vid_act_q     <= 1'b0;
            vid_clr_q     <= 1'b0;
            vid_wr_q      <= 1'b0;
            vid_addr_q    <= 16'd0;
            vid_data_q    <= 16'd0;
            print_valid_q <= 1'b0;
            print_dec_q   <= 1'b0;
            print_data_q  <= 16'd0;
            halt_q        <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            bad_code_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sys_prev_q    <= sys_signal;
            code_q        <= code_d;
            arg_q         <= arg_d;
            data_q        <= data_d;
            idx_q         <= idx_d;
            load_signal_q <= load_signal_d;
            load_data_q   <= load_data_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
            trig_re_q     <= trig_re_d;
            trig_addr_q   <= trig_addr_d;
            vid_act_q     <= vid_act_d;
            vid_clr_q     <= vid_clr_d;
            vid_wr_q      <= vid_wr_d;
            vid_addr_q    <= vid_addr_d;
            vid_data_q    <= vid_data_d;
            print_valid_q <= print_valid_d;
            print_dec_q   <= print_dec_d;
            print_data_q  <= print_data_d;
            halt_q        <= halt_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            bad_code_q    <= bad_code_d;
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_we         = mem_we_q;
    assign mem_re         = mem_re_q;
    assign trig_addr      = trig_addr_q;
    assign trig_re        = trig_re_q;
    assign load_signal    = load_signal_q;
    assign load_data      = load_data_q;
    assign video_activate = vid_act_q;
    assign video_clear    = vid_clr_q;
    assign video_write    = vid_wr_q;
    assign video_addr     = vid_addr_q;
    assign video_data     = vid_data_q;
    assign print_valid    = print_valid_q;
    assign print_data     = print_data_q;
    assign print_dec      = print_dec_q;
    assign halt           = halt_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;
    assign bad_code       = bad_code_q;

endmodule

// File: tb/tb_syscall_ctrl.sv
// Directed bench for syscall_ctrl with memory, trig table and print sink models.
module tb_syscall_ctrl;

    logic        clk = 1'b0;
    logic        clear_n, sys_signal, print_ready;
    logic [47:0] sysregs;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, trig_rdata, load_data;
    logic        mem_we, mem_re, trig_re, load_signal;
    logic [9:0]  trig_addr;
    logic        video_activate, video_clear, video_write;
    logic [15:0] video_addr, video_data, print_data;
    logic        print_valid, print_dec, halt, busy, overrun, bad_code;

    logic [15:0] mem [0:65535];
    logic [16:0] hs_q[$];
    int          n_we = 0, n_re = 0, n_trig = 0, n_vw = 0;
    int          n_chk = 0, n_pass = 0;
    int          k, c0;

    always #5 clk = ~clk;

    syscall_ctrl #(.STR_MAX(4)) dut (
        .clk(clk), .clear_n(clear_n), .sys_signal(sys_signal), .sysregs(sysregs),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .trig_addr(trig_addr), .trig_re(trig_re),
        .trig_rdata(trig_rdata), .load_signal(load_signal), .load_data(load_data),
        .video_activate(video_activate), .video_clear(video_clear),
        .video_write(video_write), .video_addr(video_addr), .video_data(video_data),
        .print_valid(print_valid), .print_ready(print_ready), .print_data(print_data),
        .print_dec(print_dec), .halt(halt), .busy(busy), .overrun(overrun),
        .bad_code(bad_code)
    );

    // Memory and trig table models with one-cycle read latency
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        mem_rdata  <= mem_re ? mem[mem_addr] : 16'h0000;
        trig_rdata <= trig_re ? ({6'd0, trig_addr} + 16'd100) : 16'h0000;
    end

    // Strobe counters and print handshake log
    always @(posedge clk) begin
        if (mem_we) n_we++;
        if (mem_re) n_re++;
        if (trig_re) n_trig++;
        if (video_write) n_vw++;
        if (print_valid && print_ready) hs_q.push_back({print_dec, print_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic syscall(input logic [15:0] c, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        sysregs    = {d, a, c};
        sys_signal = 1'b1;
        @(negedge clk);
        sys_signal = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        clear_n = 1'b0; sys_signal = 1'b0; sysregs = 48'd0; print_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_load_signal", {31'd0, load_signal}, 32'd0);
        check("rst_print_valid", {31'd0, print_valid}, 32'd0);
        check("rst_flags", {30'd0, overrun, bad_code}, 32'd0);
        check("rst_strobes", {26'd0, mem_we, mem_re, trig_re, video_activate, video_clear, video_write}, 32'd0);
        clear_n = 1'b1;

        syscall(16'd1, 16'h0040, 16'hBEEF);
        check("wr_we", {31'd0, mem_we}, 32'd1);
        check("wr_addr", mem_addr, 32'h0040);
        check("wr_wdata", mem_wdata, 32'hBEEF);
        check("wr_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("wr_one_cycle", {31'd0, mem_we}, 32'd0);
        check("wr_busy_drop", {31'd0, busy}, 32'd0);

        syscall(16'd2, 16'h0040, 16'h0000);
        check("rd_re", {31'd0, mem_re}, 32'd1);
        @(negedge clk);
        check("rd_not_yet", {31'd0, load_signal}, 32'd0);
        @(negedge clk);
        check("rd_load_signal", {31'd0, load_signal}, 32'd1);
        check("rd_load_data", load_data, 32'hBEEF);

        syscall(16'd10, 16'd45, 16'h0000);
        check("trig_re", {31'd0, trig_re}, 32'd1);
        check("trig_addr", {22'd0, trig_addr}, 32'd91);
        check("trig_no_mem_re", {31'd0, mem_re}, 32'd0);
        repeat (2) @(negedge clk);
        check("trig_data", load_data, 32'd191);
        check("trig_bad_clear", {31'd0, bad_code}, 32'd0);

        c0 = n_trig;
        syscall(16'd9, 16'd400, 16'h0000);
        check("trig_bad_set", {31'd0, bad_code}, 32'd1);
        repeat (2) @(negedge clk);
        check("trig_bad_load_signal", {31'd0, load_signal}, 32'd1);
        check("trig_bad_data", load_data, 32'd0);
        check("trig_bad_no_re", n_trig - c0, 32'd0);

        k = hs_q.size();
        syscall(16'd3, 16'h0037, 16'h0000);
        check("pr_valid", {31'd0, print_valid}, 32'd1);
        check("pr_data", print_data, 32'h0037);
        check("pr_dec", {31'd0, print_dec}, 32'd1);
        syscall(16'd4, 16'h0011, 16'h0000);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check("ovr_data_stable", {15'd0, print_dec, print_data}, {15'd0, 1'b1, 16'h0037});
        @(negedge clk); print_ready = 1'b1;
        @(negedge clk); print_ready = 1'b0;
        check("pr_valid_drop", {31'd0, print_valid}, 32'd0);
        check("pr_once", hs_q.size() - k, 32'd1);
        check("pr_item", {15'd0, hs_q[k]}, {15'd0, 1'b1, 16'h0037});

        mem[16'h0100] = 16'h0048; mem[16'h0101] = 16'h0069; mem[16'h0102] = 16'h0000;
        k = hs_q.size(); c0 = n_re;
        syscall(16'd5, 16'h0100, 16'h0000);
        repeat (3) @(negedge clk);
        check("str_valid", {31'd0, print_valid}, 32'd1);
        check("str_first", print_data, 32'h0048);
        print_ready = 1'b1;
        wait_idle("str_idle");
        print_ready = 1'b0;
        check("str_count", hs_q.size() - k, 32'd2);
        check("str_H", {15'd0, hs_q[k]}, {15'd0, 17'h00048});
        check("str_i", {15'd0, hs_q[k+1]}, {15'd0, 17'h00069});
        check("str_reads", n_re - c0, 32'd3);

        for (int i = 0; i < 5; i++) mem[16'h0200 + 16'(i)] = 16'h0041 + 16'(i);
        k = hs_q.size();
        syscall(16'd5, 16'h0200, 16'h0000);
        print_ready = 1'b1;
        wait_idle("strmax_idle");
        print_ready = 1'b0;
        check("strmax_count", hs_q.size() - k, 32'd4);
        check("strmax_last", {15'd0, hs_q[hs_q.size()-1]}, {15'd0, 17'h00044});

        mem[16'hFFFE] = 16'h0061; mem[16'hFFFF] = 16'h0062;
        mem[16'h0000] = 16'h0063; mem[16'h0001] = 16'h0000;
        k = hs_q.size();
        syscall(16'd5, 16'hFFFE, 16'h0000);
        print_ready = 1'b1;
        wait_idle("wrap_idle");
        print_ready = 1'b0;
        check("wrap_count", hs_q.size() - k, 32'd3);
        check("wrap_third", {15'd0, hs_q[hs_q.size()-1]}, {15'd0, 17'h00063});

        mem[16'h0300] = 16'h0051; mem[16'h0301] = 16'h0000;
        k = hs_q.size();
        syscall(16'd5, 16'h0300, 16'h0000);
        repeat (2) @(negedge clk);
        check("rst_mid_valid", {31'd0, print_valid}, 32'd1);
        #2 clear_n = 1'b0;
        #1;
        check("rst_async_valid", {31'd0, print_valid}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_ovr", {31'd0, overrun}, 32'd0);
        sysregs = {16'h0000, 16'h005A, 16'h0004};
        sys_signal = 1'b1;
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check("held_req_valid", {31'd0, print_valid}, 32'd1);
        check("held_req_data", {15'd0, print_dec, print_data}, {15'd0, 1'b0, 16'h005A});
        sys_signal = 1'b0; print_ready = 1'b1;
        @(negedge clk);
        print_ready = 1'b0;
        check("held_req_done", {31'd0, print_valid}, 32'd0);
        check("held_req_count", hs_q.size() - k, 32'd1);
        check("held_req_item", {15'd0, hs_q[hs_q.size()-1]}, {15'd0, 17'h0005A});

        c0 = n_vw;
        syscall(16'd8, 16'd5, 16'h0041);
        check("vid_write", {31'd0, video_write}, 32'd1);
        check("vid_addr", video_addr, 32'd5);
        check("vid_data", video_data, 32'h0041);
        @(negedge clk);
        check("vid_one_cycle", n_vw - c0, 32'd1);
        syscall(16'd6, 16'd9, 16'h0077);
        check("vid_activate", {31'd0, video_activate}, 32'd1);
        check("vid_hold", {video_addr, video_data}, {16'd5, 16'h0041});

        syscall(16'd0, 16'd0, 16'd0);
        check("halt_set", {31'd0, halt}, 32'd1);
        c0 = n_we;
        syscall(16'd1, 16'h0050, 16'h1234);
        repeat (3) @(negedge clk);
        check("halt_ignored", n_we - c0, 32'd0);
        check("halt_sticky", {31'd0, halt}, 32'd1);
        check("halt_no_ovr", {31'd0, overrun}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
